dcim_sram_ctrl: RTL and testbench

Access sequencer for the DCIM SRAM array. Takes single-word read/write requests over a valid/ready handshake and drives the column periphery (`pe`, `ysw`, `ysr`, `spe`, `se`, `din`) and the one-hot wordlines through precharge, access and sense phases. For reads it captures `dout` and returns it with a response pulse. It sits between the host or weight-load logic and the bitcell/`sram_rw` array, as the initiator of the array's read/write protocol.

---
 rtl/dcim_sram_pkg.sv | 23 ++
 rtl/dcim_wl_decoder.sv | 27 ++
 rtl/dcim_sram_ctrl.sv | 145 ++++++++++++++
 tb/tb_dcim_sram_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcim_sram_pkg.sv
// Shared types and defaults for the DCIM SRAM access sequencer.
package dcim_sram_pkg;

    // Sequencer phases; DONE is the single-cycle response slot.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRE    = 3'd1,
        ST_ACCESS = 3'd2,
        ST_SENSE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int DEF_PRE_CYC = 2;
    localparam int DEF_ACC_CYC = 2;

    // Width of the shared phase down-counter, which holds at most max(pre, acc) - 1.
    function automatic int phase_cnt_w(input int pre_cyc, input int acc_cyc);
        int m;
        m = (pre_cyc > acc_cyc) ? pre_cyc : acc_cyc;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/dcim_wl_decoder.sv
// Binary-to-one-hot wordline decoder with enable and range flag.
// Addresses at or above ROWS never raise a wordline.
module dcim_wl_decoder #(
    parameter int ROWS   = 64,
    parameter int ADDR_W = 6
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] in,
    output logic [ROWS-1:0]   out,
    output logic              in_range
);

    localparam logic [ADDR_W:0] ROWS_L = (ADDR_W + 1)'(ROWS);

    assign in_range = ({1'b0, in} < ROWS_L);

    // Raise exactly the addressed wordline when enabled and in range.
    always_comb begin
        out = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (en && (in == ADDR_W'(i))) begin
                out[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcim_sram_ctrl.sv
// Access sequencer for the DCIM SRAM array: precharge, access, sense, respond.
// Handshake: a request transfers on a rising edge where req_valid and req_ready
// are both high; req_ready is high only when idle and out of reset, and the
// request fields are ignored at every other edge.
// All array controls are registered from the next-state decode so they change
// only at clock edges and line up with the phase they belong to.
module dcim_sram_ctrl
    import dcim_sram_pkg::*;
#(
    parameter int ROWS    = 64,
    parameter int WORD    = 16,
    parameter int ADDR_W  = 6,
    parameter int PRE_CYC = DEF_PRE_CYC,
    parameter int ACC_CYC = DEF_ACC_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [WORD-1:0]   rsp_rdata,
    output logic [ROWS-1:0]   wl,
    output logic              pe,
    output logic              spe,
    output logic              ysw,
    output logic              ysr,
    output logic              se,
    output logic [WORD-1:0]   din,
    input  logic [WORD-1:0]   dout
);

    localparam int CW = phase_cnt_w(PRE_CYC, ACC_CYC);

    state_t            state_q, state_n;
    logic [CW-1:0]     cnt_q, cnt_n;
    logic              we_q, we_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [WORD-1:0]   wdata_q, wdata_n;
    logic              accept;
    logic              wl_en;
    logic [ROWS-1:0]   wl_n;
    logic              in_range_n;

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Request fields seen by the next cycle: fresh on acceptance, otherwise held.
    assign we_n    = accept ? req_we    : we_q;
    assign addr_n  = accept ? req_addr  : addr_q;
    assign wdata_n = accept ? req_wdata : wdata_q;
    assign wl_en   = (state_n == ST_ACCESS);

    dcim_wl_decoder #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_wl_dec (
        .en       (wl_en),
        .in       (addr_n),
        .out      (wl_n),
        .in_range (in_range_n)
    );

    // Phase sequencing with a shared down-counter for PRE and ACCESS lengths.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_PRE;
                    cnt_n   = CW'(PRE_CYC - 1);
                end
            end
            ST_PRE: begin
                if (cnt_q == '0) begin
                    state_n = ST_ACCESS;
                    cnt_n   = CW'(ACC_CYC - 1);
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_n = we_q ? ST_DONE : ST_SENSE;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            ST_SENSE: state_n = ST_DONE;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // State, counter and latched request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
        end
    end

    // Registered array controls and response; out-of-range rows keep wl and ysw low.
    always_ff @(posedge clk) begin
        if (rst) begin
            wl        <= '0;
            pe        <= 1'b0;
            spe       <= 1'b0;
            ysw       <= 1'b0;
            ysr       <= 1'b0;
            se        <= 1'b0;
            din       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            wl        <= wl_n;
            pe        <= (state_n == ST_PRE);
            spe       <= (state_n == ST_PRE);
            ysw       <= (state_n == ST_ACCESS) && we_n && in_range_n;
            ysr       <= ((state_n == ST_ACCESS) && !we_n) || (state_n == ST_SENSE);
            se        <= (state_n == ST_SENSE);
            din       <= ((state_n == ST_ACCESS) && we_n) ? wdata_n : '0;
            rsp_valid <= (state_n == ST_DONE);
            rsp_err   <= (state_n == ST_DONE) && !in_range_n;
            if ((state_q == ST_SENSE) && in_range_n) begin
                rsp_rdata <= dout;
            end
        end
    end

endmodule

// File: tb/tb_dcim_sram_ctrl.sv
// Bench for dcim_sram_ctrl: three configurations side by side
// (defaults, ROWS=48, PRE_CYC=1/ACC_CYC=3), each driven with directed and
// random requests and checked against a phase-timeline reference model.
module tb_dcim_sram_ctrl;

    localparam int NI   = 3;
    localparam int SB_W = 51;  // {inst[1:0], err, rdata[15:0], cycle[31:0]}

    // ---------------- clock / reset ----------------
    logic clk;
    int   cyc;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_a       [NI];
    logic        req_valid_a [NI];
    logic        req_ready_a [NI];
    logic        req_we_a    [NI];
    logic [5:0]  req_addr_a  [NI];
    logic [15:0] req_wdata_a [NI];
    logic        rsp_valid_a [NI];
    logic        rsp_err_a   [NI];
    logic [15:0] rsp_rdata_a [NI];
    logic [63:0] wl_a        [NI];
    logic        pe_a        [NI];
    logic        spe_a       [NI];
    logic        ysw_a       [NI];
    logic        ysr_a       [NI];
    logic        se_a        [NI];
    logic [15:0] din_a       [NI];
    logic [15:0] dout_a      [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int R = (g == 1) ? 48 : 64;
        localparam int P = (g == 2) ? 1 : 2;
        localparam int A = (g == 2) ? 3 : 2;
        logic [R-1:0] wl_w;
        dcim_sram_ctrl #(
            .ROWS(R), .WORD(16), .ADDR_W(6), .PRE_CYC(P), .ACC_CYC(A)
        ) u_dut (
            .clk       (clk),
            .rst       (rst_a[g]),
            .req_valid (req_valid_a[g]),
            .req_ready (req_ready_a[g]),
            .req_we    (req_we_a[g]),
            .req_addr  (req_addr_a[g]),
            .req_wdata (req_wdata_a[g]),
            .rsp_valid (rsp_valid_a[g]),
            .rsp_err   (rsp_err_a[g]),
            .rsp_rdata (rsp_rdata_a[g]),
            .wl        (wl_w),
            .pe        (pe_a[g]),
            .spe       (spe_a[g]),
            .ysw       (ysw_a[g]),
            .ysr       (ysr_a[g]),
            .se        (se_a[g]),
            .din       (din_a[g]),
            .dout      (dout_a[g])
        );
        assign wl_a[g] = 64'(wl_w);
    end

    function automatic int cfg_rows(input int g);
        return (g == 1) ? 48 : 64;
    endfunction
    function automatic int cfg_pre(input int g);
        return (g == 2) ? 1 : 2;
    endfunction
    function automatic int cfg_acc(input int g);
        return (g == 2) ? 3 : 2;
    endfunction

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [SB_W-1:0] exp_q[$];

    task automatic chk(input int g, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL inst%0d %s cyc=%0d got=%0h want=%0h", g, nm, cyc, act, exp);
        end
    endtask

    // Reference memory contents and bitcell array contents start identical.
    logic [15:0] ref_mem [NI][64];
    logic [15:0] arr_mem [NI][64];
    int          last_row [NI];

    bit          armed  [NI];
    bit          act    [NI];
    int          kk     [NI];
    logic        m_we   [NI];
    logic [5:0]  m_addr [NI];
    logic [15:0] m_data [NI];
    logic [15:0] m_rexp [NI];
    logic [15:0] m_rdata[NI];

    initial begin
        for (int g = 0; g < NI; g++) begin
            for (int r = 0; r < 64; r++) begin
                ref_mem[g][r] = 16'($urandom);
                arr_mem[g][r] = ref_mem[g][r];
            end
            last_row[g] = 0;
            armed[g]    = 1'b0;
            act[g]      = 1'b0;
            kk[g]       = 0;
            m_we[g]     = 1'b0;
            m_addr[g]   = '0;
            m_data[g]   = '0;
            m_rexp[g]   = '0;
            m_rdata[g]  = '0;
            dout_a[g]   = '0;
        end
    end

    // Bitcell array model: writes on ysw with a raised wordline, returns the
    // last accessed row only while se is high and noise otherwise.
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (armed[g]) begin
                for (int r = 0; r < 64; r++) begin
                    if (wl_a[g][r] === 1'b1) begin
                        last_row[g] = r;
                        if (ysw_a[g] === 1'b1) arr_mem[g][r] = din_a[g];
                    end
                end
                dout_a[g] = (se_a[g] === 1'b1) ? arr_mem[g][last_row[g]] : 16'($urandom);
            end
        end
    end

    // Reference timeline: offset k from the acceptance cycle selects the phase.
    int          pc, t, dk;
    bit          inr, in_acc, e_pe, e_se, e_ysr, e_ysw, e_ready;
    logic [63:0] e_wl;
    logic [15:0] e_din;
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (!armed[g]) begin
                if (rst_a[g] === 1'b1) armed[g] = 1'b1;
            end else begin
                pc = cfg_pre(g);
                t  = pc + cfg_acc(g);
                if (act[g]) kk[g]++;
                dk      = m_we[g] ? t + 1 : t + 2;
                inr     = int'(m_addr[g]) < cfg_rows(g);
                in_acc  = act[g] && kk[g] > pc && kk[g] <= t;
                e_pe    = act[g] && kk[g] >= 1 && kk[g] <= pc;
                e_se    = act[g] && !m_we[g] && kk[g] == t + 1;
                e_ysr   = (in_acc && !m_we[g]) || e_se;
                e_ysw   = in_acc && m_we[g] && inr;
                e_wl    = (in_acc && inr) ? (64'd1 << m_addr[g]) : 64'd0;
                e_din   = (in_acc && m_we[g]) ? m_data[g] : 16'd0;
                e_ready = !act[g] && !rst_a[g];
                if (act[g] && !m_we[g] && kk[g] == dk) m_rdata[g] = m_rexp[g];

                chk(g, "req_ready", 64'(req_ready_a[g]), 64'(e_ready));
                chk(g, "pe",        64'(pe_a[g]),        64'(e_pe));
                chk(g, "spe",       64'(spe_a[g]),       64'(e_pe));
                chk(g, "wl",        wl_a[g],             e_wl);
                chk(g, "ysw",       64'(ysw_a[g]),       64'(e_ysw));
                chk(g, "ysr",       64'(ysr_a[g]),       64'(e_ysr));
                chk(g, "se",        64'(se_a[g]),        64'(e_se));
                chk(g, "din",       64'(din_a[g]),       64'(e_din));
                chk(g, "rsp_rdata", 64'(rsp_rdata_a[g]), 64'(m_rdata[g]));
                chk(g, "inv_pe_wl", 64'(pe_a[g] && (|wl_a[g])), 64'd0);
                chk(g, "inv_se_pe", 64'(se_a[g] && pe_a[g]),    64'd0);
                chk(g, "inv_ysw_ysr", 64'(ysw_a[g] && ysr_a[g]), 64'd0);
                chk(g, "inv_wl_onehot0", 64'($onehot0(wl_a[g])), 64'd1);

                if (act[g] && kk[g] == dk) act[g] = 1'b0;
                if (rst_a[g]) begin
                    act[g]     = 1'b0;
                    m_rdata[g] = '0;
                    for (int i = exp_q.size() - 1; i >= 0; i--) begin
                        if (exp_q[i][50:49] == 2'(g)) exp_q.delete(i);
                    end
                end else if (e_ready && req_valid_a[g]) begin
                    act[g]    = 1'b1;
                    kk[g]     = 0;
                    m_we[g]   = req_we_a[g];
                    m_addr[g] = req_addr_a[g];
                    m_data[g] = req_wdata_a[g];
                    inr       = int'(req_addr_a[g]) < cfg_rows(g);
                    dk        = req_we_a[g] ? t + 1 : t + 2;
                    m_rexp[g] = (!req_we_a[g] && inr) ? ref_mem[g][req_addr_a[g]] : m_rdata[g];
                    if (req_we_a[g] && inr) ref_mem[g][req_addr_a[g]] = req_wdata_a[g];
                    exp_q.push_back({2'(g), !inr, m_rexp[g], 32'(cyc + dk)});
                end
            end
        end
    end

    // Response monitor: pops the oldest expectation of the responding instance.
    int              idx;
    logic [SB_W-1:0] ent;
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (armed[g] && rsp_valid_a[g] === 1'b1) begin
                idx = -1;
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (idx < 0 && exp_q[i][50:49] == 2'(g)) idx = i;
                end
                if (idx < 0) begin
                    chk(g, "rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    ent = exp_q[idx];
                    exp_q.delete(idx);
                    chk(g, "rsp_cycle", 64'(cyc), 64'(ent[31:0]));
                    chk(g, "rsp_err",   64'(rsp_err_a[g]),   64'(ent[48]));
                    chk(g, "rsp_rdata_at_rsp", 64'(rsp_rdata_a[g]), 64'(ent[47:32]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic scramble(input int g);
        req_we_a[g]    = 1'($urandom_range(0, 1));
        req_addr_a[g]  = 6'($urandom_range(0, 63));
        req_wdata_a[g] = 16'($urandom);
    endtask

    task automatic idle(input int g, input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (!req_valid_a[g]) scramble(g);
        end
    endtask

    // Present a request and return just after the edge that took it.
    task automatic send(input int g, input logic we, input logic [5:0] a,
                        input logic [15:0] d, input bit keep);
        int budget;
        req_valid_a[g] = 1'b1;
        req_we_a[g]    = we;
        req_addr_a[g]  = a;
        req_wdata_a[g] = d;
        budget = 0;
        @(negedge clk);
        while (req_ready_a[g] !== 1'b1 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 40) chk(g, "accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if (!keep) begin
            req_valid_a[g] = 1'b0;
            scramble(g);
        end
    endtask

    task automatic run_inst(input int g);
        logic we;
        bit   keep;
        case (g)
            0: begin
                send(0, 1'b1, 6'd5, 16'hA5C3, 1'b0);
                idle(0, 2);
                send(0, 1'b0, 6'd5, 16'h0000, 1'b0);
                idle(0, 2);
                send(0, 1'b1, 6'd10, 16'($urandom), 1'b1);
                send(0, 1'b1, 6'd11, 16'($urandom), 1'b1);
                send(0, 1'b1, 6'd12, 16'($urandom), 1'b0);
                idle(0, 3);
                send(0, 1'b1, 6'd9, 16'h1234, 1'b0);
                idle(0, 2);
                rst_a[0] = 1'b1;
                idle(0, 1);
                rst_a[0] = 1'b0;
                idle(0, 3);
            end
            1: begin
                send(1, 1'b0, 6'd7, 16'h0000, 1'b0);
                idle(1, 1);
                send(1, 1'b0, 6'd50, 16'h0000, 1'b0);
                idle(1, 1);
                send(1, 1'b1, 6'd55, 16'hBEEF, 1'b0);
                idle(1, 2);
            end
            default: begin
                for (int i = 0; i < 3; i++) begin
                    send(2, 1'b1, 6'd0,  16'($urandom), 1'b0);
                    send(2, 1'b0, 6'd63, 16'($urandom), 1'b0);
                    send(2, 1'b1, 6'd63, 16'($urandom), 1'b0);
                    send(2, 1'b0, 6'd0,  16'($urandom), 1'b0);
                end
                idle(2, 2);
            end
        endcase
        repeat (40) begin
            we   = 1'($urandom_range(0, 1));
            keep = 1'($urandom_range(0, 1));
            send(g, we, 6'($urandom_range(0, 63)), 16'($urandom), keep);
            if (!keep) idle(g, $urandom_range(0, 3));
        end
        req_valid_a[g] = 1'b0;
        idle(g, 2);
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        for (int g = 0; g < NI; g++) begin
            rst_a[g]       = 1'b1;
            req_valid_a[g] = 1'b0;
            scramble(g);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) rst_a[g] = 1'b0;
        fork
            run_inst(0);
            run_inst(1);
            run_inst(2);
        join
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk(0, "pending_responses", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "time limit");
    end

endmodule
